// File: rtl/rou_buffer_pp_pkg.sv
// Shared constants and types for the ping-pong root-of-unity table.
package rou_buffer_pp_pkg;

    localparam int BIT_WIDTH = 64;
    localparam int MAX_LEN   = 1024;
    localparam int LINE_SIZE = 1;

    typedef enum logic {
        SWP_IDLE    = 1'b0,
        SWP_PENDING = 1'b1
    } swp_state_e;

    // Stage s uses 2**s twiddles packed LINE_SIZE per line; never narrower than 1 bit.
    function automatic int rou_addr_width(input int stage);
        int lines;
        lines = (1 << stage) / LINE_SIZE;
        return (lines <= 2) ? 1 : $clog2(lines);
    endfunction

endpackage

// File: rtl/rou_buffer_pp_bank_ram.sv
// One ROU bank: half-word lane-masked write port, NUM_RD registered read ports, no reset.
module rou_bank_ram #(
    parameter int HALF_W     = 32,
    parameter int LANES      = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_RD     = 2
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [LANES-1:0]               lane_we_i,
    input  logic [ADDR_WIDTH-1:0]          wr_addr_i,
    input  logic [HALF_W-1:0]              wr_din_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [NUM_RD*LANES*HALF_W-1:0] rd_data_o
);

    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int LINE_W = LANES*HALF_W;

    logic [LANES-1:0][HALF_W-1:0] mem_q [DEPTH];
    logic [LANES-1:0][HALF_W-1:0] rd_q  [NUM_RD];

    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            if (we_i && lane_we_i[l]) begin
                mem_q[wr_addr_i][l] <= wr_din_i;
            end
        end
        for (int p = 0; p < NUM_RD; p++) begin
            rd_q[p] <= mem_q[rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]];
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign rd_data_o[p*LINE_W +: LINE_W] = rd_q[p];
    end

endmodule

// File: rtl/rou_buffer_pp.sv
// Double-buffered ROU table: host fills the shadow bank, commit swaps banks once reads are idle.
module rou_buffer_pp #(
    parameter int BIT_WIDTH  = rou_buffer_pp_pkg::BIT_WIDTH,
    parameter int COL_NUM    = 1,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_RD     = 2,
    parameter int LANES      = 2*COL_NUM
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [BIT_WIDTH/2-1:0]              wr_din,
    input  logic [LANES-1:0]                    wr_we,
    output logic                                wr_ready,
    input  logic                                commit,
    input  logic                                rd_idle,
    output logic                                swap_done,
    output logic                                active_bank,
    output logic                                table_valid,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]        rd_addr,
    input  logic [NUM_RD-1:0]                   rd_en,
    output logic [NUM_RD*BIT_WIDTH*COL_NUM-1:0] rd_entry,
    output rou_buffer_pp_pkg::swp_state_e       dbg_swap_state
);

    import rou_buffer_pp_pkg::*;

    localparam int HALF_W = BIT_WIDTH/2;
    localparam int LINE_W = BIT_WIDTH*COL_NUM;

    swp_state_e               state_q;
    logic                     active_bank_q;
    logic [1:0]               valid_q;
    logic                     wr_ready_q;
    logic                     swap_done_q;
    logic                     sel_q;
    logic                     s1_valid_q;
    logic [NUM_RD*LINE_W-1:0] rd_entry_q, rd_entry_d;
    logic [NUM_RD*LINE_W-1:0] rd_data0, rd_data1;

    // Writes only ever target the bank that readers are not using.
    rou_bank_ram #(
        .HALF_W(HALF_W), .LANES(LANES), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD)
    ) u_bank0 (
        .clk(clk), .we_i(wr_ready_q & active_bank_q), .lane_we_i(wr_we),
        .wr_addr_i(wr_addr), .wr_din_i(wr_din), .rd_addr_i(rd_addr), .rd_data_o(rd_data0)
    );

    rou_bank_ram #(
        .HALF_W(HALF_W), .LANES(LANES), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD)
    ) u_bank1 (
        .clk(clk), .we_i(wr_ready_q & ~active_bank_q), .lane_we_i(wr_we),
        .wr_addr_i(wr_addr), .wr_din_i(wr_din), .rd_addr_i(rd_addr), .rd_data_o(rd_data1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SWP_IDLE;
            active_bank_q <= 1'b0;
            valid_q       <= 2'b00;
            wr_ready_q    <= 1'b1;
            swap_done_q   <= 1'b0;
        end else begin
            swap_done_q <= 1'b0;
            case (state_q)
                SWP_IDLE: begin
                    if (commit) begin
                        state_q    <= SWP_PENDING;
                        wr_ready_q <= 1'b0;
                    end
                end
                SWP_PENDING: begin
                    if (rd_idle) begin
                        state_q                 <= SWP_IDLE;
                        active_bank_q           <= ~active_bank_q;
                        valid_q[~active_bank_q] <= 1'b1;
                        wr_ready_q              <= 1'b1;
                        swap_done_q             <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Stage-1 data lives in the banks; remember which bank it came from and whether it was committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            rd_entry_q <= '0;
        end else begin
            sel_q      <= active_bank_q;
            s1_valid_q <= valid_q[active_bank_q];
            rd_entry_q <= rd_entry_d;
        end
    end

    // Uncommitted banks hold undefined RAM contents, so they read as zero.
    always_comb begin
        rd_entry_d = rd_entry_q;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_en[p]) begin
                if (s1_valid_q) begin
                    rd_entry_d[p*LINE_W +: LINE_W] = sel_q ? rd_data1[p*LINE_W +: LINE_W]
                                                           : rd_data0[p*LINE_W +: LINE_W];
                end else begin
                    rd_entry_d[p*LINE_W +: LINE_W] = '0;
                end
            end
        end
    end

    assign wr_ready       = wr_ready_q;
    assign swap_done      = swap_done_q;
    assign active_bank    = active_bank_q;
    assign table_valid    = valid_q[active_bank_q];
    assign rd_entry       = rd_entry_q;
    assign dbg_swap_state = state_q;

endmodule

// File: tb/tb_rou_buffer_pp.sv
// Bench for rou_buffer_pp: directed vector table, corner sequences, random traffic against a bank model.
module tb_rou_buffer_pp;

    import rou_buffer_pp_pkg::*;

    localparam int AW    = 9;
    localparam int DEPTH = 2**AW;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     wr_addr;
    logic [31:0]       wr_din;
    logic [1:0]        wr_we;
    logic              wr_ready;
    logic              commit;
    logic              rd_idle;
    logic              swap_done;
    logic              active_bank;
    logic              table_valid;
    logic [2*AW-1:0]   rd_addr;
    logic [1:0]        rd_en;
    logic [127:0]      rd_entry;
    swp_state_e        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    rou_buffer_pp dut (
        .clk(clk), .rst(rst), .wr_addr(wr_addr), .wr_din(wr_din), .wr_we(wr_we),
        .wr_ready(wr_ready), .commit(commit), .rd_idle(rd_idle), .swap_done(swap_done),
        .active_bank(active_bank), .table_valid(table_valid), .rd_addr(rd_addr),
        .rd_en(rd_en), .rd_entry(rd_entry), .dbg_swap_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: two banks of lines, a pending-swap flag and a two-deep read pipe.
    logic [31:0] m_mem   [2][DEPTH][2];
    bit   [1:0]  m_known [2][DEPTH];
    bit          m_pending, m_active, m_wr_ready, m_swap_done, m_s1_valid;
    bit   [1:0]  m_valid;
    logic [63:0] m_s1 [2];
    bit   [1:0]  m_s1_known;
    logic [63:0] m_rd [2];
    bit   [1:0]  m_rd_known = 2'b00;
    logic [63:0] fill_val [2][DEPTH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        logic [63:0] n_s1 [2];
        bit   [1:0]  n_s1_known;
        bit          n_s1_valid;
        logic [63:0] n_rd [2];
        bit   [1:0]  n_rd_known;
        logic [AW-1:0] a;
        bit sh;
        if (rst) begin
            m_pending = 0; m_active = 0; m_valid = 0; m_wr_ready = 1;
            m_swap_done = 0; m_s1_valid = 0;
            m_rd[0] = '0; m_rd[1] = '0; m_rd_known = 2'b11;
        end else begin
            n_rd = m_rd;
            n_rd_known = m_rd_known;
            for (int p = 0; p < 2; p++) begin
                a = rd_addr[p*AW +: AW];
                n_s1[p] = {m_mem[m_active][a][1], m_mem[m_active][a][0]};
                n_s1_known[p] = &m_known[m_active][a];
                if (rd_en[p]) begin
                    n_rd[p] = m_s1_valid ? m_s1[p] : 64'd0;
                    n_rd_known[p] = m_s1_valid ? m_s1_known[p] : 1'b1;
                end
            end
            n_s1_valid = m_valid[m_active];
            if (m_wr_ready) begin
                sh = ~m_active;
                for (int l = 0; l < 2; l++) begin
                    if (wr_we[l]) begin
                        m_mem[sh][wr_addr][l] = wr_din;
                        m_known[sh][wr_addr][l] = 1'b1;
                    end
                end
            end
            m_swap_done = 0;
            if (!m_pending) begin
                if (commit) begin
                    m_pending = 1; m_wr_ready = 0;
                end
            end else if (rd_idle) begin
                m_active = ~m_active;
                m_valid[m_active] = 1'b1;
                m_pending = 0; m_wr_ready = 1; m_swap_done = 1;
            end
            m_s1 = n_s1; m_s1_known = n_s1_known; m_s1_valid = n_s1_valid;
            m_rd = n_rd; m_rd_known = n_rd_known;
        end
        @(posedge clk);
        #1;
        check("active_bank", {63'd0, active_bank}, {63'd0, m_active});
        check("wr_ready", {63'd0, wr_ready}, {63'd0, m_wr_ready});
        check("swap_done", {63'd0, swap_done}, {63'd0, m_swap_done});
        check("table_valid", {63'd0, table_valid}, {63'd0, m_valid[m_active]});
        check("state_pending", {63'd0, dbg_state == SWP_PENDING}, {63'd0, m_pending});
        for (int p = 0; p < 2; p++) begin
            if (m_rd_known[p]) check($sformatf("rd_entry%0d", p), rd_entry[p*64 +: 64], m_rd[p]);
        end
    endtask

    task automatic write_line(input logic [AW-1:0] a, input logic [63:0] v);
        fill_val[!m_active][a] = v;
        wr_addr = a; wr_din = v[31:0]; wr_we = 2'b01; step();
        wr_din = v[63:32]; wr_we = 2'b10; step();
        wr_we = 2'b00;
    endtask

    task automatic fill_shadow();
        for (int a = 0; a < DEPTH; a++) write_line(AW'(a), {$urandom, $urandom});
    endtask

    task automatic do_swap();
        commit = 1'b1; step();
        commit = 1'b0; rd_idle = 1'b1; step();
        rd_idle = 1'b0;
        check("swap_pulse", {63'd0, swap_done}, 64'd1);
    endtask

    task automatic read_port0(input logic [AW-1:0] a, output logic [63:0] d);
        rd_addr[AW-1:0] = a; rd_en = 2'b01;
        step(); step();
        d = rd_entry[63:0];
        rd_en = 2'b00;
    endtask

    typedef struct {
        bit          rst, commit, idle;
        bit   [1:0]  we;
        logic [AW-1:0] waddr;
        logic [31:0] din;
        logic [AW-1:0] raddr;
        bit   [1:0]  ren;
        bit          e_active, e_ready, e_done, e_valid;
        logic [63:0] e_rd0;
    } vec_t;

    vec_t tbl [8];
    logic [63:0] rd_val;

    initial begin
        rst = 1'b1; wr_addr = '0; wr_din = '0; wr_we = '0; commit = 1'b0;
        rd_idle = 1'b0; rd_addr = '0; rd_en = '0;

        // rst commit idle we waddr din raddr ren | active ready done valid rd0
        tbl[0] = '{1, 0, 0, 2'b00, 9'd0, 32'h0,         9'd9, 2'b00, 0, 1, 0, 0, 64'h0};
        tbl[1] = '{0, 0, 0, 2'b00, 9'd0, 32'h0,         9'd9, 2'b11, 0, 1, 0, 0, 64'h0};
        tbl[2] = '{0, 0, 0, 2'b00, 9'd0, 32'h0,         9'd9, 2'b11, 0, 1, 0, 0, 64'h0};
        tbl[3] = '{0, 0, 0, 2'b01, 9'd5, 32'h0000_1111, 9'd9, 2'b11, 0, 1, 0, 0, 64'h0};
        tbl[4] = '{0, 1, 0, 2'b10, 9'd5, 32'h0000_2222, 9'd9, 2'b11, 0, 0, 0, 0, 64'h0};
        tbl[5] = '{0, 0, 1, 2'b00, 9'd0, 32'h0,         9'd9, 2'b11, 1, 1, 1, 1, 64'h0};
        tbl[6] = '{0, 0, 0, 2'b00, 9'd0, 32'h0,         9'd5, 2'b01, 1, 1, 0, 1, 64'h0};
        tbl[7] = '{0, 0, 0, 2'b00, 9'd0, 32'h0,         9'd5, 2'b01, 1, 1, 0, 1, 64'h0000_2222_0000_1111};

        step();
        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst; commit = tbl[i].commit; rd_idle = tbl[i].idle;
            wr_we = tbl[i].we; wr_addr = tbl[i].waddr; wr_din = tbl[i].din;
            rd_addr = {tbl[i].raddr, tbl[i].raddr}; rd_en = tbl[i].ren;
            step();
            check($sformatf("tbl%0d_active", i), {63'd0, active_bank}, {63'd0, tbl[i].e_active});
            check($sformatf("tbl%0d_ready", i), {63'd0, wr_ready}, {63'd0, tbl[i].e_ready});
            check($sformatf("tbl%0d_done", i), {63'd0, swap_done}, {63'd0, tbl[i].e_done});
            check($sformatf("tbl%0d_valid", i), {63'd0, table_valid}, {63'd0, tbl[i].e_valid});
            check($sformatf("tbl%0d_rd0", i), rd_entry[63:0], tbl[i].e_rd0);
            check($sformatf("tbl%0d_rd1", i), rd_entry[127:64], 64'h0);
        end
        rst = 0; commit = 0; rd_idle = 0; wr_we = 0; rd_en = 0;

        // Long pending: writes attempted while the swap waits must be dropped.
        fill_shadow();
        commit = 1'b1; step(); commit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_addr = 9'd20; wr_din = 32'hDEAD_BEEF; wr_we = 2'b11;
            step();
            check("pend_ready", {63'd0, wr_ready}, 64'd0);
            check("pend_active", {63'd0, active_bank}, 64'd1);
        end
        wr_we = 2'b00; rd_idle = 1'b1; step(); rd_idle = 1'b0;
        check("pend_swap_active", {63'd0, active_bank}, 64'd0);
        check("pend_swap_done", {63'd0, swap_done}, 64'd1);
        read_port0(9'd20, rd_val);
        check("dropped_write", rd_val, fill_val[0][20]);

        fill_shadow();
        do_swap();

        // Commit together with rd_idle waits one edge; commit while pending is ignored.
        commit = 1'b1; rd_idle = 1'b1; step();
        check("same_cyc_active", {63'd0, active_bank}, 64'd1);
        check("same_cyc_ready", {63'd0, wr_ready}, 64'd0);
        step();
        check("next_edge_active", {63'd0, active_bank}, 64'd0);
        check("next_edge_done", {63'd0, swap_done}, 64'd1);
        commit = 1'b0; rd_idle = 1'b0; step();
        check("after_swap_ready", {63'd0, wr_ready}, 64'd1);
        check("after_swap_done", {63'd0, swap_done}, 64'd0);

        // Independent ports: port 1 keeps its last line when its enable is low.
        rd_addr = {9'd9, 9'd9}; rd_en = 2'b11; step(); step();
        rd_addr = {9'd7, 9'd3}; rd_en = 2'b01; step(); step();
        check("port0_addr3", rd_entry[63:0], fill_val[0][3]);
        check("port1_hold", rd_entry[127:64], fill_val[0][9]);
        rd_en = 2'b00;

        // Lane-0-only write merges into an existing line.
        write_line(9'd40, 64'hAAAA_BBBB_CCCC_DDDD);
        wr_addr = 9'd40; wr_din = 32'h1234_5678; wr_we = 2'b01; step(); wr_we = 2'b00;
        do_swap();
        read_port0(9'd40, rd_val);
        check("lane0_merge", rd_val, 64'hAAAA_BBBB_1234_5678);

        // Reset while pending: back to bank 0, nothing valid, no pulse, RAM kept.
        commit = 1'b1; step(); commit = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_active", {63'd0, active_bank}, 64'd0);
        check("rst_valid", {63'd0, table_valid}, 64'd0);
        check("rst_ready", {63'd0, wr_ready}, 64'd1);
        check("rst_done", {63'd0, swap_done}, 64'd0);
        rd_idle = 1'b1; step(); rd_idle = 1'b0;
        check("rst_no_swap", {63'd0, active_bank}, 64'd0);
        check("rst_no_done", {63'd0, swap_done}, 64'd0);
        do_swap();
        check("rst_reswap_active", {63'd0, active_bank}, 64'd1);
        read_port0(9'd40, rd_val);
        check("ram_kept_40", rd_val, 64'hAAAA_BBBB_1234_5678);
        read_port0(9'd100, rd_val);
        check("ram_kept_100", rd_val, fill_val[1][100]);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            commit  = ($urandom_range(0, 7) == 0);
            rd_idle = $urandom_range(0, 1) == 1;
            wr_we   = 2'($urandom);
            wr_addr = AW'($urandom);
            wr_din  = $urandom;
            rd_addr = (2*AW)'($urandom);
            rd_en   = 2'($urandom);
            step();
        end
        rst = 1'b0; commit = 1'b0; wr_we = 2'b00; rd_en = 2'b00;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
